// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED mode controller.
// Mode encoding matches the MODE output (0..3).
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      COUNT     = 2'd1,
      BOUNCE    = 2'd2,
      ACTIVITY  = 2'd3
   } mode_e;

   localparam logic [7:0] LED_BLINK_INIT = 8'hAA;
   localparam logic [7:0] BOUNCE_INIT    = 8'h01;
   localparam logic [7:0] BOUNCE_TOP     = 8'h80;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser + debouncer with a 1-cycle press pulse.
// Ports: clk, rst_n (async, low), key_n (raw, low=pressed), press (pulse).
module key_debounce #(
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync;
   logic          key_s;
   logic          level;
   logic [CW-1:0] cnt;

   assign key_s = sync[1];

   // cnt holds how many consecutive cycles key_s has differed from the
   // accepted level; the level flips on the cycle that completes the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key_n};
         press <= 1'b0;
         if (key_s == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= key_s;
            press <= ~key_s;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_mode_ctrl.sv
// Four-mode LED bank controller: lock-wait blink, counter, bounce, rx history.
// Ports: CLK, RST_N (async, low), LOCK, KEY_N, RX_ACT (async in), LED[7:0], MODE[1:0].
module led_mode_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV     = 4_000_000,
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       LOCK,
   input  logic       KEY_N,
   input  logic       RX_ACT,
   output logic [7:0] LED,
   output logic [1:0] MODE
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

   logic [1:0]    lock_sync;
   logic [1:0]    rx_sync;
   logic          lock_s;
   logic          rx_s;
   logic          press;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [7:0]    cnt8;
   mode_e         mode;
   mode_e         mode_nxt;
   logic [7:0]    led_nxt;
   logic          dir_up;
   logic          dir_nxt;
   logic          flag;
   logic          flag_nxt;
   logic [7:0]    up_val;
   logic [7:0]    dn_val;

   assign lock_s = lock_sync[1];
   assign rx_s   = rx_sync[1];
   assign tick   = (tcnt == TLAST);
   assign MODE   = mode;
   assign up_val = {LED[6:0], 1'b0};
   assign dn_val = {1'b0, LED[7:1]};

   key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_key (
      .clk  (CLK),
      .rst_n(RST_N),
      .key_n(KEY_N),
      .press(press)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lock_sync <= 2'b00;
         rx_sync   <= 2'b00;
         tcnt      <= '0;
         cnt8      <= 8'h00;
      end else begin
         lock_sync <= {lock_sync[0], LOCK};
         rx_sync   <= {rx_sync[0], RX_ACT};
         tcnt      <= tick ? '0 : tcnt + TW'(1);
         if (tick) cnt8 <= cnt8 + 8'd1;
      end
   end

   // Lock loss wins over a press in the same cycle.
   always_comb begin
      mode_nxt = mode;
      unique case (mode)
         WAIT_LOCK: if (lock_s) mode_nxt = COUNT;
         COUNT: begin
            if (!lock_s)    mode_nxt = WAIT_LOCK;
            else if (press) mode_nxt = BOUNCE;
         end
         BOUNCE: begin
            if (!lock_s)    mode_nxt = WAIT_LOCK;
            else if (press) mode_nxt = ACTIVITY;
         end
         ACTIVITY: begin
            if (!lock_s)    mode_nxt = WAIT_LOCK;
            else if (press) mode_nxt = COUNT;
         end
      endcase
   end

   // A mode entry loads the entry value and swallows a coincident tick.
   always_comb begin
      led_nxt  = LED;
      dir_nxt  = dir_up;
      flag_nxt = flag;
      if (mode_nxt != mode) begin
         unique case (mode_nxt)
            WAIT_LOCK: led_nxt = LED_BLINK_INIT;
            COUNT:     led_nxt = cnt8;
            BOUNCE: begin
               led_nxt = BOUNCE_INIT;
               dir_nxt = 1'b1;
            end
            ACTIVITY: begin
               led_nxt  = 8'h00;
               flag_nxt = 1'b0;
            end
         endcase
      end else begin
         unique case (mode)
            WAIT_LOCK: if (tick) led_nxt = ~LED;
            COUNT:     led_nxt = cnt8;
            BOUNCE: begin
               if (tick) begin
                  if (dir_up) begin
                     led_nxt = up_val;
                     if (up_val == BOUNCE_TOP) dir_nxt = 1'b0;
                  end else begin
                     led_nxt = dn_val;
                     if (dn_val == BOUNCE_INIT) dir_nxt = 1'b1;
                  end
               end
            end
            ACTIVITY: begin
               if (tick) begin
                  led_nxt  = {LED[6:0], flag | rx_s};
                  flag_nxt = 1'b0;
               end else if (rx_s) begin
                  flag_nxt = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode   <= WAIT_LOCK;
         LED    <= LED_BLINK_INIT;
         dir_up <= 1'b1;
         flag   <= 1'b0;
      end else begin
         mode   <= mode_nxt;
         LED    <= led_nxt;
         dir_up <= dir_nxt;
         flag   <= flag_nxt;
      end
   end

endmodule
